bmem_word_bridge: RTL

Memory-side bridge between the out-of-order core's two word ports (imem, dmem) and the single 256-bit line port (bmem) used once caches are removed from the path. It latches word requests from both ports, arbitrates them onto bmem with fixed dmem priority, and services them:

- **Reads:** one line fetch, then the addressed word is extracted.
- **Writes:** a line read-modify-write (fetch, byte-merge under `wmask`, write back).

The response is returned to the requesting port as a one-cycle pulse.

---
 rtl/rv32i_types.sv | 22 ++
 rtl/bmem_word_bridge.sv | 135 +++++++++++++
 2 files changed

// File: rtl/rv32i_types.sv
// Shared types for the word-to-line memory bridge: pending request slot and bridge FSM states.
package rv32i_types;

    localparam int DEFAULT_LINE_WIDTH = 256;
    localparam int LINE_OFS           = $clog2(DEFAULT_LINE_WIDTH / 8);

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  rmask;
        logic [3:0]  wmask;
        logic [31:0] wdata;
        logic        valid;
    } word_req_t;

    typedef enum logic [1:0] {
        IDLE,
        RD,
        WR,
        RESP
    } bridge_state_t;

endpackage

// File: rtl/bmem_word_bridge.sv
// Bridges the imem/dmem word ports onto one line-wide bmem port; dmem has fixed priority,
// stores are done as line read-modify-write.
module bmem_word_bridge
    import rv32i_types::*;
#(
    parameter int LINE_WIDTH = DEFAULT_LINE_WIDTH,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic [3:0]            imem_rmask,
    output logic [31:0]           imem_rdata,
    output logic                  imem_resp,
    input  logic [ADDR_WIDTH-1:0] dmem_addr,
    input  logic [3:0]            dmem_rmask,
    input  logic [3:0]            dmem_wmask,
    input  logic [31:0]           dmem_wdata,
    output logic [31:0]           dmem_rdata,
    output logic                  dmem_resp,
    output logic [ADDR_WIDTH-1:0] bmem_addr,
    output logic                  bmem_read,
    output logic                  bmem_write,
    output logic [LINE_WIDTH-1:0] bmem_wdata,
    input  logic [LINE_WIDTH-1:0] bmem_rdata,
    input  logic                  bmem_resp
);

    localparam int OFS  = $clog2(LINE_WIDTH / 8);
    localparam int WSEL = OFS - 2;

    function automatic logic [31:0] word_sel(input logic [LINE_WIDTH-1:0] line,
                                             input logic [WSEL-1:0] w);
        return line[32*w +: 32];
    endfunction

    function automatic logic [LINE_WIDTH-1:0] byte_merge(input logic [LINE_WIDTH-1:0] line,
                                                         input logic [WSEL-1:0] w,
                                                         input logic [3:0] mask,
                                                         input logic [31:0] data);
        logic [LINE_WIDTH-1:0] merged;
        merged = line;
        for (int b = 0; b < 4; b++) begin
            if (mask[b]) merged[32*w + 8*b +: 8] = data[8*b +: 8];
        end
        return merged;
    endfunction

    bridge_state_t          state_reg, state_next;
    logic                   served_dmem_reg, served_dmem_next;
    word_req_t              imem_slot_reg, dmem_slot_reg;
    logic [LINE_WIDTH-1:0]  line_reg;
    word_req_t              sel;
    logic [WSEL-1:0]        sel_word;
    logic [ADDR_WIDTH-1:0]  sel_line_addr;
    logic                   imem_req, dmem_req;
    logic                   unused_ok;

    assign imem_req      = |imem_rmask;
    assign dmem_req      = (|dmem_rmask) || (|dmem_wmask);
    assign sel           = served_dmem_reg ? dmem_slot_reg : imem_slot_reg;
    assign sel_word      = sel.addr[OFS-1:2];
    assign sel_line_addr = {sel.addr[ADDR_WIDTH-1:OFS], {OFS{1'b0}}};
    assign unused_ok     = ^{sel.addr[1:0], sel.rmask};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= IDLE;
            served_dmem_reg <= 1'b0;
            imem_slot_reg   <= '0;
            dmem_slot_reg   <= '0;
            line_reg        <= '0;
        end else begin
            state_reg       <= state_next;
            served_dmem_reg <= served_dmem_next;
            if (state_reg == RD && bmem_resp) line_reg <= bmem_rdata;
            if (state_reg == RESP) begin
                if (served_dmem_reg) dmem_slot_reg.valid <= 1'b0;
                else                 imem_slot_reg.valid <= 1'b0;
            end
            // A new request latched in the RESP cycle must win over the slot clear above.
            if (imem_req) imem_slot_reg <= '{addr: imem_addr, rmask: imem_rmask,
                                             wmask: 4'b0, wdata: 32'b0, valid: 1'b1};
            if (dmem_req) dmem_slot_reg <= '{addr: dmem_addr, rmask: dmem_rmask,
                                             wmask: dmem_wmask, wdata: dmem_wdata, valid: 1'b1};
        end
    end

    always_comb begin
        state_next       = state_reg;
        served_dmem_next = served_dmem_reg;
        bmem_read        = 1'b0;
        bmem_write       = 1'b0;
        bmem_addr        = '0;
        bmem_wdata       = '0;
        imem_resp        = 1'b0;
        imem_rdata       = '0;
        dmem_resp        = 1'b0;
        dmem_rdata       = '0;
        case (state_reg)
            IDLE: begin
                if (dmem_slot_reg.valid || dmem_req) begin
                    served_dmem_next = 1'b1;
                    state_next       = RD;
                end else if (imem_slot_reg.valid || imem_req) begin
                    served_dmem_next = 1'b0;
                    state_next       = RD;
                end
            end
            RD: begin
                bmem_read = 1'b1;
                bmem_addr = sel_line_addr;
                if (bmem_resp) state_next = (|sel.wmask) ? WR : RESP;
            end
            WR: begin
                bmem_write = 1'b1;
                bmem_addr  = sel_line_addr;
                bmem_wdata = byte_merge(line_reg, sel_word, sel.wmask, sel.wdata);
                if (bmem_resp) state_next = RESP;
            end
            RESP: begin
                if (served_dmem_reg) begin
                    dmem_resp  = 1'b1;
                    dmem_rdata = word_sel(line_reg, sel_word);
                end else begin
                    imem_resp  = 1'b1;
                    imem_rdata = word_sel(line_reg, sel_word);
                end
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

endmodule
